// File: rtl/aoi221_deglitch_pkg.sv
// Shared types and parameter legality checks for the aoi221 ZN deglitch filter.
package aoi221_deglitch_pkg;

    typedef enum logic {
        STABLE = 1'b0,
        PEND   = 1'b1
    } dg_state_e;

    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned SYNC_STAGES_MAX = 4;
    localparam int unsigned CNT_W_MAX       = 31;

    // True when the synchroniser depth, filter length and counter width are consistent.
    function automatic bit params_ok(input int unsigned sync_stages,
                                     input int unsigned filt_cycles,
                                     input int unsigned cnt_w);
        bit ok;
        ok = (sync_stages >= SYNC_STAGES_MIN) && (sync_stages <= SYNC_STAGES_MAX)
          && (filt_cycles >= 1) && (cnt_w >= 1) && (cnt_w <= CNT_W_MAX);
        if (ok) begin
            ok = ((32'd1 << cnt_w) > filt_cycles);
        end
        return ok;
    endfunction

endpackage

// File: rtl/zn_sync_chain.sv
// Multi-flop synchroniser bringing the asynchronous ZN net into the local clock domain.
module zn_sync_chain
    import aoi221_deglitch_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_s
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_s = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/aoi221_zn_deglitch.sv
// Synchronised, stable-count deglitched view of an aoi221 ZN net with registered
// level, edge pulses and a pending-transition flag.
module aoi221_zn_deglitch
    import aoi221_deglitch_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CYCLES = 4,
    parameter int unsigned CNT_W       = 3,
    parameter logic        RESET_VAL   = 1'b1
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    input  logic ZN_IN,
    output logic Q,
    output logic RISE,
    output logic FALL,
    output logic BUSY,
    inout  wire  VDD,
    inout  wire  VSS
);

    if (!params_ok(SYNC_STAGES, FILT_CYCLES, CNT_W)) begin : g_bad_params
        $error("aoi221_zn_deglitch: illegal SYNC_STAGES/FILT_CYCLES/CNT_W combination");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Supplies are carried for netlist connectivity only.
    wire w_unused_supply;
    assign w_unused_supply = VDD ^ VSS;

    logic w_s;

    zn_sync_chain #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (RESET_VAL)
    ) u_sync (
        .i_clk (CLK),
        .i_rst (RST),
        .i_d   (ZN_IN),
        .o_s   (w_s)
    );

    dg_state_e        r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nx;
    logic             r_q,     w_q_nx;
    logic             r_rise,  w_rise_nx;
    logic             r_fall,  w_fall_nx;
    logic             r_busy,  w_busy_nx;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= STABLE;
            r_cnt   <= '0;
            r_q     <= RESET_VAL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_q     <= w_q_nx;
            r_rise  <= w_rise_nx;
            r_fall  <= w_fall_nx;
            r_busy  <= w_busy_nx;
        end
    end

    // With EN low everything holds and the edge pulses are suppressed.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_q_nx     = r_q;
        w_rise_nx  = 1'b0;
        w_fall_nx  = 1'b0;
        if (EN) begin
            case (r_state)
                STABLE: begin
                    if (w_s != r_q) begin
                        if (FILT_CYCLES == 1) begin
                            w_q_nx    = ~r_q;
                            w_rise_nx = ~r_q;
                            w_fall_nx = r_q;
                        end else begin
                            w_cnt_nx   = CNT_ONE;
                            w_state_nx = PEND;
                        end
                    end
                end
                PEND: begin
                    if (w_s == r_q) begin
                        w_cnt_nx   = '0;
                        w_state_nx = STABLE;
                    end else if (r_cnt == CNT_LAST) begin
                        w_q_nx     = ~r_q;
                        w_rise_nx  = ~r_q;
                        w_fall_nx  = r_q;
                        w_cnt_nx   = '0;
                        w_state_nx = STABLE;
                    end else begin
                        w_cnt_nx = r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    w_cnt_nx   = '0;
                    w_state_nx = STABLE;
                end
            endcase
        end
        w_busy_nx = (w_state_nx == PEND);
    end

    assign Q    = r_q;
    assign RISE = r_rise;
    assign FALL = r_fall;
    assign BUSY = r_busy;

endmodule
